// File: rtl/tpu_pkg.sv
// Constants and FSM encodings shared across the TPU datapath blocks.
package tpu_pkg;

    localparam int unsigned DEF_MATRIX_SIZE    = 16;
    localparam int unsigned DEF_PARTIAL_SUM_BW = 24;
    localparam int unsigned DEF_ADDRESSSIZE    = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } wb_state_t;

endpackage

// File: rtl/tpu_result_writeback_if.sv
// Job request, systolic result bus and result-SRAM write port of the writeback block.
interface tpu_result_writeback_if
    import tpu_pkg::*;
#(
    parameter int unsigned MATRIX_SIZE    = DEF_MATRIX_SIZE,
    parameter int unsigned PARTIAL_SUM_BW = DEF_PARTIAL_SUM_BW,
    parameter int unsigned ADDRESSSIZE    = DEF_ADDRESSSIZE
);
    logic                                   start;
    logic [ADDRESSSIZE-1:0]                 base_addr;
    logic [ADDRESSSIZE:0]                   num_rows;
    logic                                   relu_en;
    logic                                   rev_en;
    logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0]  result_in;
    logic                                   sram_we;
    logic [ADDRESSSIZE-1:0]                 sram_address;
    logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0]  sram_data;
    logic                                   busy;
    logic                                   done;

    modport master (
        output start, base_addr, num_rows, relu_en, rev_en, result_in,
        input  sram_we, sram_address, sram_data, busy, done
    );

    modport slave (
        input  start, base_addr, num_rows, relu_en, rev_en, result_in,
        output sram_we, sram_address, sram_data, busy, done
    );

endinterface

// File: rtl/tpu_deskew_line.sv
// Fixed-depth delay line for one result lane; DEPTH of zero degenerates to a wire.
module tpu_deskew_line #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (DEPTH == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = &{1'b0, clk, rstn};
        assign q = d;
    end else begin : g_pipe
        logic [WIDTH-1:0] pipe [DEPTH];

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                for (int i = 0; i < int'(DEPTH); i++) pipe[i] <= '0;
            end else begin
                pipe[0] <= d;
                for (int i = 1; i < int'(DEPTH); i++) pipe[i] <= pipe[i-1];
            end
        end

        assign q = pipe[DEPTH-1];
    end

endmodule

// File: rtl/tpu_result_writeback.sv
// Deskews systolic column outputs, applies optional ReLU / lane reversal and
// writes one aligned row per cycle into the result SRAM.
module tpu_result_writeback
    import tpu_pkg::*;
#(
    parameter int unsigned MATRIX_SIZE    = DEF_MATRIX_SIZE,
    parameter int unsigned PARTIAL_SUM_BW = DEF_PARTIAL_SUM_BW,
    parameter int unsigned ADDRESSSIZE    = DEF_ADDRESSSIZE,
    parameter int unsigned LATENCY        = 2*MATRIX_SIZE
) (
    input  logic                   clk,
    input  logic                   rstn,
    tpu_result_writeback_if.slave  bus
);

    localparam int unsigned ROW_W       = PARTIAL_SUM_BW*MATRIX_SIZE;
    localparam int unsigned WAIT_CYCLES = LATENCY + MATRIX_SIZE - 1;
    localparam int unsigned ROWS_W      = ADDRESSSIZE + 1;
    localparam int unsigned WAIT_W      = $clog2(WAIT_CYCLES + 1);
    localparam int unsigned CNT_W       = (WAIT_W > ROWS_W) ? WAIT_W : ROWS_W;

    wb_state_t              state, state_d;
    logic [CNT_W-1:0]       cnt, cnt_d;
    logic [ADDRESSSIZE-1:0] base_q;
    logic [ADDRESSSIZE:0]   rows_q;
    logic                   relu_q;
    logic                   rev_q;

    logic [PARTIAL_SUM_BW-1:0] aligned [MATRIX_SIZE];
    logic [ROW_W-1:0]          row_next;

    // Lane j arrives j cycles late, so it is delayed by the complement to line up with lane MATRIX_SIZE-1.
    for (genvar j = 0; j < MATRIX_SIZE; j++) begin : g_lane
        tpu_deskew_line #(
            .WIDTH (PARTIAL_SUM_BW),
            .DEPTH (MATRIX_SIZE - 1 - j)
        ) u_deskew (
            .clk  (clk),
            .rstn (rstn),
            .d    (bus.result_in[j*PARTIAL_SUM_BW +: PARTIAL_SUM_BW]),
            .q    (aligned[j])
        );
    end

    // ReLU commutes with the lane permutation, so clamp after selecting the source lane.
    for (genvar s = 0; s < MATRIX_SIZE; s++) begin : g_slot
        logic [PARTIAL_SUM_BW-1:0] lane_sel;
        assign lane_sel = rev_q ? aligned[MATRIX_SIZE-1-s] : aligned[s];
        assign row_next[s*PARTIAL_SUM_BW +: PARTIAL_SUM_BW] =
            (relu_q && lane_sel[PARTIAL_SUM_BW-1]) ? '0 : lane_sel;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // cnt counts WAIT cycles, then doubles as the row index during WRITE.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        unique case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    cnt_d   = '0;
                    state_d = (bus.num_rows == '0) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt == CNT_W'(WAIT_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_WRITE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ST_WRITE: begin
                cnt_d = cnt + CNT_W'(1);
                if (cnt_d == CNT_W'(rows_q)) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            base_q <= '0;
            rows_q <= '0;
            relu_q <= 1'b0;
            rev_q  <= 1'b0;
        end else if (state == ST_IDLE && bus.start) begin
            base_q <= bus.base_addr;
            rows_q <= bus.num_rows;
            relu_q <= bus.relu_en;
            rev_q  <= bus.rev_en;
        end
    end

    // Status and write port are registered copies of the next state, so they track the state exactly.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.sram_we      <= 1'b0;
            bus.sram_address <= '0;
            bus.sram_data    <= '0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
        end else begin
            bus.sram_we <= (state_d == ST_WRITE);
            bus.busy    <= (state_d == ST_WAIT) || (state_d == ST_WRITE);
            bus.done    <= (state_d == ST_DONE);
            if (state_d == ST_WRITE) begin
                bus.sram_address <= base_q + ADDRESSSIZE'(cnt_d);
                bus.sram_data    <= row_next;
            end
        end
    end

endmodule

// File: tb/tb_tpu_result_writeback.sv
// Bench for tpu_result_writeback: table of jobs plus hand-written abort/back-to-back sequences.
module tb_tpu_result_writeback;

    localparam int MS    = 4;
    localparam int PSB   = 16;
    localparam int AS    = 4;
    localparam int LAT   = 8;
    localparam int WAITC = LAT + MS - 1;
    localparam int ROW_W = MS * PSB;
    localparam int NVEC  = 10;

    typedef struct {
        logic [AS-1:0]  base;
        logic [AS:0]    rows;
        logic           relu;
        logic           rev;
        int             off;
        int             neg;
        logic [AS-1:0]  exp_last_addr;
        logic [PSB-1:0] exp_last_slot0;
    } vec_t;

    typedef struct {
        logic [AS-1:0]    addr;
        logic [ROW_W-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    tpu_result_writeback_if #(.MATRIX_SIZE(MS), .PARTIAL_SUM_BW(PSB), .ADDRESSSIZE(AS)) bus ();

    tpu_result_writeback #(
        .MATRIX_SIZE(MS), .PARTIAL_SUM_BW(PSB), .ADDRESSSIZE(AS), .LATENCY(LAT)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int j_e0   = -1000;
    int j_rows = 0;
    int j_off  = 0;
    int j_neg  = -1;

    wr_t              sb_q[$];
    logic [AS-1:0]    last_addr;
    logic [ROW_W-1:0] last_data;
    int               n_writes;

    vec_t vecs [NVEC];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int raw_val(input int off, input int neg, input int r, input int j);
        int v;
        v = off + 16*r + j;
        if (j == neg) v = -7;
        return v;
    endfunction

    // Skewed source: row r lane j must be stable at edge e0+LAT+r+j; other slots carry noise.
    initial begin
        bus.result_in = '0;
        forever begin
            @(negedge clk);
            for (int j = 0; j < MS; j++) begin
                int r;
                r = (cyc + 1) - j_e0 - LAT - j;
                if (r >= 0 && r < j_rows)
                    bus.result_in[j*PSB +: PSB] = PSB'(raw_val(j_off, j_neg, r, j));
                else
                    bus.result_in[j*PSB +: PSB] = PSB'($urandom);
            end
        end
    end

    // Write monitor: every sram_we must match the head of the scoreboard.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bus.sram_we === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0h data %0h with empty scoreboard (cycle %0d)",
                             bus.sram_address, bus.sram_data, cyc);
                end else begin
                    wr_t e;
                    e = sb_q.pop_front();
                    chk("wr_addr", 64'(bus.sram_address), 64'(e.addr));
                    chk("wr_data", 64'(bus.sram_data), 64'(e.data));
                    last_addr = bus.sram_address;
                    last_data = bus.sram_data;
                    n_writes++;
                end
            end
        end
    end

    // Drive a start for the next edge and queue the writes it should produce.
    task automatic launch(input vec_t v);
        bus.base_addr = v.base;
        bus.num_rows  = v.rows;
        bus.relu_en   = v.relu;
        bus.rev_en    = v.rev;
        bus.start     = 1'b1;
        j_e0   = cyc + 1;
        j_rows = int'(v.rows);
        j_off  = v.off;
        j_neg  = v.neg;
        n_writes = 0;
        for (int r = 0; r < int'(v.rows); r++) begin
            wr_t e;
            e.data = '0;
            for (int j = 0; j < MS; j++) begin
                int val;
                int slot;
                val  = raw_val(v.off, v.neg, r, j);
                if (v.relu && val < 0) val = 0;
                slot = v.rev ? (MS - 1 - j) : j;
                e.data[slot*PSB +: PSB] = PSB'(val);
            end
            e.addr = AS'(int'(v.base) + r);
            sb_q.push_back(e);
        end
    endtask

    // Follow a launched job to its done pulse; optionally re-pulse start (with junk config) at step repulse_k.
    task automatic finish_job(input vec_t v, input int repulse_k);
        int first_we;
        int done_k;
        first_we = -1;
        done_k   = -1;
        for (int k = 0; k < 100 && done_k < 0; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                bus.start = 1'b0;
                chk("busy_after_start", 64'(bus.busy), 64'(v.rows != 0));
            end
            if (k == repulse_k) begin
                bus.start     = 1'b1;
                bus.num_rows  = '0;
                bus.base_addr = '0;
                bus.relu_en   = ~v.relu;
            end
            if (k == repulse_k + 1) bus.start = 1'b0;
            if (bus.sram_we === 1'b1 && first_we < 0) first_we = k;
            if (bus.done === 1'b1) done_k = k;
        end
        chk("done_latency", 64'(done_k), 64'((v.rows == 0) ? 0 : WAITC + int'(v.rows)));
        chk("first_we_latency", 64'(first_we), 64'((v.rows == 0) ? -1 : WAITC));
        chk("busy_in_done", 64'(bus.busy), 64'(0));
        chk("sb_drained", 64'(sb_q.size()), 64'(0));
        chk("write_count", 64'(n_writes), 64'(v.rows));
        if (v.rows != 0) begin
            chk("last_addr", 64'(last_addr), 64'(v.exp_last_addr));
            chk("last_slot0", 64'(last_data[PSB-1:0]), 64'(v.exp_last_slot0));
        end
    endtask

    task automatic idle_after(input vec_t v);
        @(posedge clk);
        #1;
        chk("done_one_cycle", 64'(bus.done), 64'(0));
        chk("we_idle", 64'(bus.sram_we), 64'(0));
        if (v.rows != 0) chk("addr_hold", 64'(bus.sram_address), 64'(last_addr));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        //           base   rows   relu  rev   off  neg  last  slot0
        vecs[0] = '{4'd5,  5'd4,  1'b0, 1'b0,   0, -1, 4'd8,  16'd48};
        vecs[1] = '{4'd5,  5'd4,  1'b1, 1'b0,   0,  2, 4'd8,  16'd48};
        vecs[2] = '{4'd5,  5'd4,  1'b0, 1'b1,   0, -1, 4'd8,  16'd51};
        vecs[3] = '{4'd5,  5'd4,  1'b1, 1'b1,   0,  2, 4'd8,  16'd51};
        vecs[4] = '{4'd14, 5'd4,  1'b0, 1'b0,   0, -1, 4'd1,  16'd48};
        vecs[5] = '{4'd7,  5'd0,  1'b0, 1'b0,   0, -1, 4'd0,  16'd0};
        vecs[6] = '{4'd3,  5'd3,  1'b1, 1'b1, -20, -1, 4'd5,  16'd15};
        vecs[7] = '{4'd0,  5'd16, 1'b0, 1'b0, -20, -1, 4'd15, 16'd220};
        vecs[8] = '{4'd9,  5'd1,  1'b0, 1'b0,   0, -1, 4'd9,  16'd0};
        vecs[9] = '{4'd2,  5'd2,  1'b0, 1'b0,   0,  2, 4'd3,  16'd16};

        rstn          = 1'b0;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.num_rows  = '0;
        bus.relu_en   = 1'b0;
        bus.rev_en    = 1'b0;
        last_addr     = '0;
        last_data     = '0;
        n_writes      = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", 64'(bus.sram_we), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
        chk("rst_addr", 64'(bus.sram_address), 64'(0));
        chk("rst_data", 64'(bus.sram_data), 64'(0));
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            launch(vecs[i]);
            finish_job(vecs[i], -1);
            idle_after(vecs[i]);
        end

        // start re-pulsed during WRITE (with num_rows=0) must not disturb the job
        @(negedge clk);
        launch(vecs[0]);
        finish_job(vecs[0], WAITC + 1);
        idle_after(vecs[0]);

        // start in the DONE cycle is dropped; start in the following IDLE cycle runs
        @(negedge clk);
        launch(vecs[8]);
        finish_job(vecs[8], -1);
        bus.start    = 1'b1;
        bus.num_rows = '0;
        @(posedge clk);
        #1;
        chk("b2b_ignored_busy", 64'(bus.busy), 64'(0));
        chk("b2b_ignored_done", 64'(bus.done), 64'(0));
        launch(vecs[2]);
        finish_job(vecs[2], -1);
        idle_after(vecs[2]);

        // reset asserted while row 2 is being written
        @(negedge clk);
        launch(vecs[0]);
        for (int k = 0; k <= WAITC + 2; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) bus.start = 1'b0;
        end
        chk("abort_we_before", 64'(bus.sram_we), 64'(1));
        #1;
        rstn = 1'b0;
        #1;
        chk("abort_we", 64'(bus.sram_we), 64'(0));
        chk("abort_busy", 64'(bus.busy), 64'(0));
        chk("abort_done", 64'(bus.done), 64'(0));
        sb_q.delete();
        j_rows = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk("post_abort_done", 64'(bus.done), 64'(0));
            chk("post_abort_busy", 64'(bus.busy), 64'(0));
        end

        @(negedge clk);
        launch(vecs[4]);
        finish_job(vecs[4], -1);
        idle_after(vecs[4]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tpu_result_writeback.md
TPU_RESULT_WRITEBACK -- requirements
Module: tpu_result_writeback

Interface
REQ-001 Parameter MATRIX_SIZE, default 16: number of systolic columns and result lanes.
REQ-002 Parameter PARTIAL_SUM_BW, default 24: signed partial-sum width per lane.
REQ-003 Parameter ADDRESSSIZE, default 10: result SRAM address width.
REQ-004 Parameter LATENCY, default 2*MATRIX_SIZE: cycles from start to arrival of row 0, column 0 at result_in.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rstn  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  one-cycle request to begin a writeback job.
REQ-008 base_addr  input  ADDRESSSIZE  first SRAM address of the job; sampled with start.
REQ-009 num_rows  input  ADDRESSSIZE+1  rows to write, 0..2^ADDRESSSIZE; sampled with start.
REQ-010 relu_en  input  1  1 = clamp negative lanes to 0; sampled with start.
REQ-011 rev_en  input  1  1 = reverse lane order (lane j written to slot MATRIX_SIZE-1-j); sampled with start.
REQ-012 result_in  input  PARTIAL_SUM_BW*MATRIX_SIZE  skewed systolic outputs; lane j occupies bits [j*PARTIAL_SUM_BW +: PARTIAL_SUM_BW].
REQ-013 sram_we  output  1  result SRAM write enable.
REQ-014 sram_address  output  ADDRESSSIZE  result SRAM write address.
REQ-015 sram_data  output  PARTIAL_SUM_BW*MATRIX_SIZE  deskewed, post-processed row.
REQ-016 busy  output  1  high from the cycle after an accepted start until done.
REQ-017 done  output  1  one-cycle pulse at job end.

Function
REQ-018 FSM states IDLE, WAIT, WRITE, DONE; IDLE->WAIT on start with num_rows>0; IDLE->DONE on start with num_rows==0.
REQ-019 WAIT lasts exactly LATENCY+MATRIX_SIZE-1 cycles, then ->WRITE; WRITE lasts exactly num_rows cycles, then ->DONE; DONE lasts 1 cycle, then ->IDLE.
REQ-020 start SHALL be ignored outside IDLE; parameter/config inputs are sampled only on an accepted start.
REQ-021 Row r, lane j is present on result_in at edge E0+LATENCY+r+j, where E0 is the edge sampling start.
REQ-022 Lane j SHALL pass through a deskew delay of MATRIX_SIZE-1-j cycles, so all lanes of row r are aligned.
REQ-023 Row r SHALL appear on sram_data with sram_we=1 and sram_address=base_addr+r in WRITE cycle r (one output register after alignment).
REQ-024 Address arithmetic wraps modulo 2^ADDRESSSIZE; num_rows=2^ADDRESSSIZE writes every address exactly once.
REQ-025 relu_en=1: any lane with sign bit set is written as 0; otherwise the lane is passed unchanged; no width change.
REQ-026 rev_en is applied after ReLU; it is pure lane permutation, with no extra latency.
REQ-027 sram_we SHALL be 0 in all states except WRITE; sram_address/sram_data hold their last value when sram_we=0.
REQ-028 done SHALL be high exactly in the DONE state; busy SHALL be high in WAIT and WRITE only.
REQ-029 start asserted in the DONE cycle is ignored; start in the following IDLE cycle is accepted (back-to-back jobs).

Reset
REQ-030 On rstn low: FSM->IDLE; sram_we, busy, done = 0; sram_address and sram_data = 0; deskew registers, counters and captured config = 0.
REQ-031 Reset mid-job aborts immediately; no further writes and no done pulse are produced.
REQ-032 After rstn rises, the first edge may accept start.

Structure
REQ-033 Package tpu_pkg holds FSM state encodings and the default MATRIX_SIZE/PARTIAL_SUM_BW/ADDRESSSIZE constants shared across the TPU.
REQ-034 Sub-module tpu_deskew_line (parameters WIDTH, DEPTH; DEPTH=0 means a wire) is instantiated once per lane; the rest stays flat.

Verification
REQ-035 MATRIX_SIZE=4, LATENCY=8, base_addr=5, num_rows=4, lanes drive value 16*r+j per skew -> writes at addresses 5..8 with row r lanes 16r+0..16r+3; first sram_we 8+3+1 cycles after start; done 1 cycle after the last write.
REQ-036 Same setup with relu_en=1, lane 2 driving -7 -> lane 2 written as 0; with rev_en=1 -> lane 0 slot holds original lane 3.
REQ-037 ADDRESSSIZE=4, base_addr=14, num_rows=4 -> addresses 14, 15, 0, 1.
REQ-038 num_rows=0 -> no sram_we; done pulses in the cycle after start; busy stays 0.
REQ-039 start re-pulsed while busy -> ignored; rstn low during WRITE row 2 -> sram_we=0 at once, no done; new job after reset completes normally.
